// File: rtl/dynamic_buffer_fetch_arbiter_pkg.sv
// Shared definitions for the dynamic buffer fetch arbiter: slot geometry,
// channel indices and the arbiter state encoding.
package dynamic_buffer_fetch_arbiter_pkg;

  localparam int MAX_DB_SLOT_NUM_LOG      = 12;
  localparam int PACKET_BUFFER_SLOT_WIDTH = 512;

  localparam logic CHNL_0 = 1'b0;
  localparam logic CHNL_1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_0  = 3'd1,
    ST_REQ_1  = 3'd2,
    ST_RESP_0 = 3'd3,
    ST_RESP_1 = 3'd4
  } fetch_arb_state_t;

endpackage

// File: rtl/dynamic_buffer_fetch_arbiter.sv
// Two-channel round-robin fetch arbiter: forwards one head-slot request at a time
// to the buffer and steers the multi-beat response back. Optional macro DB_FETCH_ARB_STAT_EN adds per-channel fetch counters.
module dynamic_buffer_fetch_arbiter
  import dynamic_buffer_fetch_arbiter_pkg::*;
#(
  parameter int SLOT_NUM_LOG = MAX_DB_SLOT_NUM_LOG,
  parameter int SLOT_WIDTH   = PACKET_BUFFER_SLOT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    chnl_0_req_valid,
  input  logic [SLOT_NUM_LOG-1:0] chnl_0_req_head,
  output logic                    chnl_0_req_ready,
  output logic                    chnl_0_resp_valid,
  output logic                    chnl_0_resp_start,
  output logic                    chnl_0_resp_last,
  output logic [SLOT_WIDTH-1:0]   chnl_0_resp_data,
  input  logic                    chnl_0_resp_ready,

  input  logic                    chnl_1_req_valid,
  input  logic [SLOT_NUM_LOG-1:0] chnl_1_req_head,
  output logic                    chnl_1_req_ready,
  output logic                    chnl_1_resp_valid,
  output logic                    chnl_1_resp_start,
  output logic                    chnl_1_resp_last,
  output logic [SLOT_WIDTH-1:0]   chnl_1_resp_data,
  input  logic                    chnl_1_resp_ready,

  output logic                    fetch_req_valid,
  output logic [SLOT_NUM_LOG-1:0] fetch_req_head,
  input  logic                    fetch_req_ready,
  input  logic                    fetch_resp_valid,
  input  logic                    fetch_resp_start,
  input  logic                    fetch_resp_last,
  input  logic [SLOT_WIDTH-1:0]   fetch_resp_data,
  output logic                    fetch_resp_ready
`ifdef DB_FETCH_ARB_STAT_EN
  ,
  output logic [31:0]             chnl_0_fetch_cnt,
  output logic [31:0]             chnl_1_fetch_cnt
`endif
);

  fetch_arb_state_t state, state_nxt;
  logic             last_sch_chnl, last_sch_chnl_nxt;
  logic             pkt_done_0, pkt_done_1;

  // Final-beat handshake of the packet currently steered to each channel.
  assign pkt_done_0 = (state == ST_RESP_0) && fetch_resp_valid && chnl_0_resp_ready && fetch_resp_last;
  assign pkt_done_1 = (state == ST_RESP_1) && fetch_resp_valid && chnl_1_resp_ready && fetch_resp_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_sch_chnl <= CHNL_0;
    end else begin
      state         <= state_nxt;
      last_sch_chnl <= last_sch_chnl_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    last_sch_chnl_nxt = last_sch_chnl;
    case (state)
      ST_IDLE: begin
        // The channel not served last gets first pick.
        if (last_sch_chnl == CHNL_0) begin
          if (chnl_1_req_valid)      state_nxt = ST_REQ_1;
          else if (chnl_0_req_valid) state_nxt = ST_REQ_0;
        end else begin
          if (chnl_0_req_valid)      state_nxt = ST_REQ_0;
          else if (chnl_1_req_valid) state_nxt = ST_REQ_1;
        end
      end
      ST_REQ_0:  if (chnl_0_req_valid && fetch_req_ready) state_nxt = ST_RESP_0;
      ST_REQ_1:  if (chnl_1_req_valid && fetch_req_ready) state_nxt = ST_RESP_1;
      ST_RESP_0: if (pkt_done_0) begin
        state_nxt         = ST_IDLE;
        last_sch_chnl_nxt = CHNL_0;
      end
      ST_RESP_1: if (pkt_done_1) begin
        state_nxt         = ST_IDLE;
        last_sch_chnl_nxt = CHNL_1;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    chnl_0_req_ready  = 1'b0;
    chnl_0_resp_valid = 1'b0;
    chnl_0_resp_start = 1'b0;
    chnl_0_resp_last  = 1'b0;
    chnl_0_resp_data  = '0;
    chnl_1_req_ready  = 1'b0;
    chnl_1_resp_valid = 1'b0;
    chnl_1_resp_start = 1'b0;
    chnl_1_resp_last  = 1'b0;
    chnl_1_resp_data  = '0;
    fetch_req_valid   = 1'b0;
    fetch_req_head    = '0;
    fetch_resp_ready  = 1'b0;
    case (state)
      ST_REQ_0: begin
        fetch_req_valid  = chnl_0_req_valid;
        fetch_req_head   = chnl_0_req_head;
        chnl_0_req_ready = fetch_req_ready;
      end
      ST_REQ_1: begin
        fetch_req_valid  = chnl_1_req_valid;
        fetch_req_head   = chnl_1_req_head;
        chnl_1_req_ready = fetch_req_ready;
      end
      ST_RESP_0: begin
        chnl_0_resp_valid = fetch_resp_valid;
        chnl_0_resp_start = fetch_resp_start;
        chnl_0_resp_last  = fetch_resp_last;
        chnl_0_resp_data  = fetch_resp_data;
        fetch_resp_ready  = chnl_0_resp_ready;
      end
      ST_RESP_1: begin
        chnl_1_resp_valid = fetch_resp_valid;
        chnl_1_resp_start = fetch_resp_start;
        chnl_1_resp_last  = fetch_resp_last;
        chnl_1_resp_data  = fetch_resp_data;
        fetch_resp_ready  = chnl_1_resp_ready;
      end
      default: ;
    endcase
  end

`ifdef DB_FETCH_ARB_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chnl_0_fetch_cnt <= '0;
      chnl_1_fetch_cnt <= '0;
    end else begin
      if (pkt_done_0) chnl_0_fetch_cnt <= sat_inc(chnl_0_fetch_cnt);
      if (pkt_done_1) chnl_1_fetch_cnt <= sat_inc(chnl_1_fetch_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dynamic_buffer_fetch_arbiter.sv
// Directed self-checking bench for dynamic_buffer_fetch_arbiter; also checks the
// fetch counters when DB_FETCH_ARB_STAT_EN is defined.
module tb_dynamic_buffer_fetch_arbiter;

  localparam int SNL = 12;
  localparam int SW  = 512;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           chnl_0_req_valid, chnl_1_req_valid;
  logic [SNL-1:0] chnl_0_req_head, chnl_1_req_head;
  logic           chnl_0_req_ready, chnl_1_req_ready;
  logic           chnl_0_resp_valid, chnl_0_resp_start, chnl_0_resp_last;
  logic           chnl_1_resp_valid, chnl_1_resp_start, chnl_1_resp_last;
  logic [SW-1:0]  chnl_0_resp_data, chnl_1_resp_data;
  logic           chnl_0_resp_ready, chnl_1_resp_ready;
  logic           fetch_req_valid, fetch_req_ready;
  logic [SNL-1:0] fetch_req_head;
  logic           fetch_resp_valid, fetch_resp_start, fetch_resp_last, fetch_resp_ready;
  logic [SW-1:0]  fetch_resp_data;
`ifdef DB_FETCH_ARB_STAT_EN
  logic [31:0]    chnl_0_fetch_cnt, chnl_1_fetch_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dynamic_buffer_fetch_arbiter #(.SLOT_NUM_LOG(SNL), .SLOT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .chnl_0_req_valid(chnl_0_req_valid), .chnl_0_req_head(chnl_0_req_head),
    .chnl_0_req_ready(chnl_0_req_ready), .chnl_0_resp_valid(chnl_0_resp_valid),
    .chnl_0_resp_start(chnl_0_resp_start), .chnl_0_resp_last(chnl_0_resp_last),
    .chnl_0_resp_data(chnl_0_resp_data), .chnl_0_resp_ready(chnl_0_resp_ready),
    .chnl_1_req_valid(chnl_1_req_valid), .chnl_1_req_head(chnl_1_req_head),
    .chnl_1_req_ready(chnl_1_req_ready), .chnl_1_resp_valid(chnl_1_resp_valid),
    .chnl_1_resp_start(chnl_1_resp_start), .chnl_1_resp_last(chnl_1_resp_last),
    .chnl_1_resp_data(chnl_1_resp_data), .chnl_1_resp_ready(chnl_1_resp_ready),
    .fetch_req_valid(fetch_req_valid), .fetch_req_head(fetch_req_head),
    .fetch_req_ready(fetch_req_ready), .fetch_resp_valid(fetch_resp_valid),
    .fetch_resp_start(fetch_resp_start), .fetch_resp_last(fetch_resp_last),
    .fetch_resp_data(fetch_resp_data), .fetch_resp_ready(fetch_resp_ready)
`ifdef DB_FETCH_ARB_STAT_EN
    , .chnl_0_fetch_cnt(chnl_0_fetch_cnt), .chnl_1_fetch_cnt(chnl_1_fetch_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    chnl_0_req_valid = 0; chnl_0_req_head = '0; chnl_0_resp_ready = 1;
    chnl_1_req_valid = 0; chnl_1_req_head = '0; chnl_1_resp_ready = 1;
    fetch_req_ready = 1; fetch_resp_valid = 0; fetch_resp_start = 0;
    fetch_resp_last = 0; fetch_resp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic beat(input logic s, input logic l, input logic [SW-1:0] d);
    fetch_resp_valid = 1; fetch_resp_start = s; fetch_resp_last = l; fetch_resp_data = d;
  endtask

  task automatic no_beat();
    fetch_resp_valid = 0; fetch_resp_start = 0; fetch_resp_last = 0; fetch_resp_data = '0;
  endtask

`ifdef DB_FETCH_ARB_STAT_EN
  // One full two-beat fetch on channel ch, from IDLE back to IDLE.
  task automatic do_fetch(input int ch, input logic [SNL-1:0] head);
    if (ch == 0) begin chnl_0_req_valid = 1; chnl_0_req_head = head; end
    else begin chnl_1_req_valid = 1; chnl_1_req_head = head; end
    tick();                      // REQ_x, accepted at next edge
    tick();                      // RESP_x
    chnl_0_req_valid = 0; chnl_1_req_valid = 0;
    beat(1, 0, 512'h1);
    tick();
    beat(0, 1, 512'h2);
    tick();                      // IDLE
    no_beat();
  endtask
`endif

  initial begin
    logic [SW-1:0] d0, d1, d2;
    d0 = {16{32'hA5A5_0000}};
    d1 = {16{32'h5A5A_1111}};
    d2 = {16{32'hDEAD_2222}};

    // ---- reset state
    idle_inputs();
    rst_n = 0;
    settle();
    chk("rst_fetch_req_valid", fetch_req_valid, 0);
    chk("rst_fetch_resp_ready", fetch_resp_ready, 0);
    chk("rst_last_sch", dut.last_sch_chnl, 0);
    tick();
    rst_n = 1;
    tick();

    // ---- channel 0 alone, head 0x005, 3-beat response
    chnl_0_req_valid = 1; chnl_0_req_head = 12'h005;
    settle();
    chk("t1_idle_req_valid", fetch_req_valid, 0);
    tick();                                   // REQ_0
    chk("t1_req_valid", fetch_req_valid, 1);
    chk("t1_req_head", fetch_req_head, 12'h005);
    chk("t1_c0_req_ready", chnl_0_req_ready, 1);
    chk("t1_c1_req_ready", chnl_1_req_ready, 0);
    tick();                                   // RESP_0
    chnl_0_req_valid = 0;
    chk("t1_req_valid_resp", fetch_req_valid, 0);
    beat(1, 0, d0);
    settle();
    chk("t1_b0_valid", chnl_0_resp_valid, 1);
    chk("t1_b0_start", chnl_0_resp_start, 1);
    chk("t1_b0_data", chnl_0_resp_data, d0);
    chk("t1_b0_c1_valid", chnl_1_resp_valid, 0);
    chk("t1_b0_c1_data", chnl_1_resp_data, 0);
    chk("t1_b0_fready", fetch_resp_ready, 1);
    tick();
    beat(0, 0, d1);
    settle();
    chk("t1_b1_data", chnl_0_resp_data, d1);
    chk("t1_b1_start", chnl_0_resp_start, 0);
    chk("t1_b1_c1_valid", chnl_1_resp_valid, 0);
    tick();
    beat(0, 1, d2);
    settle();
    chk("t1_b2_data", chnl_0_resp_data, d2);
    chk("t1_b2_last", chnl_0_resp_last, 1);
    tick();                                   // IDLE
    no_beat();
    chk("t1_idle_c0_valid", chnl_0_resp_valid, 0);
    chk("t1_idle_fready", fetch_resp_ready, 0);
    chk("t1_last_sch", dut.last_sch_chnl, 0);

    // ---- both request after reset: channel 1 first, then channel 0
    do_reset();
    chnl_0_req_valid = 1; chnl_0_req_head = 12'h010;
    chnl_1_req_valid = 1; chnl_1_req_head = 12'h020;
    tick();                                   // REQ_1
    chk("t2_first_head", fetch_req_head, 12'h020);
    chk("t2_c1_req_ready", chnl_1_req_ready, 1);
    chk("t2_c0_req_ready", chnl_0_req_ready, 0);
    tick();                                   // RESP_1
    chnl_1_req_valid = 0;
    beat(1, 1, d1);
    settle();
    chk("t2_c1_resp_valid", chnl_1_resp_valid, 1);
    chk("t2_c1_resp_data", chnl_1_resp_data, d1);
    chk("t2_c0_resp_valid", chnl_0_resp_valid, 0);
    tick();                                   // IDLE
    no_beat();
    chk("t2_last_sch", dut.last_sch_chnl, 1);
    fetch_req_ready = 0;
    tick();                                   // REQ_0, held by fetch_req_ready=0
    chk("t2_second_head", fetch_req_head, 12'h010);
    chk("t2_second_c0_ready", chnl_0_req_ready, 0);

    // ---- stray response while in REQ_0 must stall
    beat(1, 1, d2);
    settle();
    chk("t3_req0_fready", fetch_resp_ready, 0);
    chk("t3_req0_c0_valid", chnl_0_resp_valid, 0);
    tick();
    chk("t3_req0_fready_2", fetch_resp_ready, 0);
    fetch_req_ready = 1;
    tick();                                   // RESP_0
    chnl_0_req_valid = 0;
    chk("t3_resp0_fready", fetch_resp_ready, 1);
    chk("t3_resp0_c0_data", chnl_0_resp_data, d2);
    chk("t3_resp0_c1_valid", chnl_1_resp_valid, 0);
    tick();                                   // IDLE
    no_beat();
    chk("t3_last_sch", dut.last_sch_chnl, 0);

    // ---- channel 1 back-pressure mid-burst
    chnl_1_req_valid = 1; chnl_1_req_head = 12'h030;
    tick();                                   // REQ_1
    chk("t4_head", fetch_req_head, 12'h030);
    tick();                                   // RESP_1
    chnl_1_req_valid = 0;
    beat(1, 0, d0);
    tick();
    beat(0, 0, d1);
    chnl_1_resp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t4_stall%0d_fready", i), fetch_resp_ready, 0);
      chk($sformatf("t4_stall%0d_data", i), chnl_1_resp_data, d1);
      chk($sformatf("t4_stall%0d_valid", i), chnl_1_resp_valid, 1);
      tick();
    end
    chnl_1_resp_ready = 1;
    settle();
    chk("t4_resume_fready", fetch_resp_ready, 1);
    tick();
    beat(0, 1, d2);
    settle();
    chk("t4_last_data", chnl_1_resp_data, d2);
    chk("t4_last_flag", chnl_1_resp_last, 1);
    tick();                                   // IDLE
    no_beat();
    chk("t4_last_sch", dut.last_sch_chnl, 1);

    // ---- reset during beat 2 of a 5-beat burst
    chnl_0_req_valid = 1; chnl_0_req_head = 12'h040;
    tick();                                   // REQ_0
    tick();                                   // RESP_0
    chnl_0_req_valid = 0;
    beat(1, 0, d0);
    tick();
    beat(0, 0, d1);
    tick();
    beat(0, 0, d2);
    settle();
    chk("t5_pre_rst_valid", chnl_0_resp_valid, 1);
    rst_n = 0;
    settle();
    chk("t5_rst_c0_valid", chnl_0_resp_valid, 0);
    chk("t5_rst_c0_data", chnl_0_resp_data, 0);
    chk("t5_rst_fready", fetch_resp_ready, 0);
    chk("t5_rst_req_valid", fetch_req_valid, 0);
    tick();
    no_beat();
    rst_n = 1;
    tick();
    chnl_0_req_valid = 1; chnl_0_req_head = 12'h041;
    settle();
    chk("t5_post_idle", fetch_req_valid, 0);
    tick();                                   // REQ_0
    chk("t5_post_req_valid", fetch_req_valid, 1);
    chk("t5_post_head", fetch_req_head, 12'h041);
    tick();                                   // RESP_0
    chnl_0_req_valid = 0;
    beat(1, 1, d0);
    settle();
    chk("t5_post_resp", chnl_0_resp_data, d0);
    tick();
    no_beat();

`ifdef DB_FETCH_ARB_STAT_EN
    // ---- statistics counters
    do_reset();
    chk("t6_cnt0_rst", chnl_0_fetch_cnt, 0);
    chk("t6_cnt1_rst", chnl_1_fetch_cnt, 0);
    do_fetch(0, 12'h100);
    do_fetch(1, 12'h101);
    do_fetch(0, 12'h102);
    do_fetch(1, 12'h103);
    do_fetch(0, 12'h104);
    chk("t6_cnt0", chnl_0_fetch_cnt, 3);
    chk("t6_cnt1", chnl_1_fetch_cnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dynamic_buffer_fetch_arbiter.md
Name: dynamic_buffer_fetch_arbiter

Overview:
- Two-channel round-robin arbiter for reading packets out of the dynamic packet buffer; the fetch-side counterpart of the insert arbiter.
- Each channel issues a single-beat fetch request carrying a packet head slot index. The block forwards one request at a time to the buffer's fetch port.
- It then steers the multi-beat slot response (start/last/data) back to the granted channel.
- The grant is held until the last response beat completes. Sits between protocol-engine consumers and the dynamic buffer fetch port.

Parameters:
- SLOT_NUM_LOG, 12, width of a slot index; matches MAX_DB_SLOT_NUM_LOG.
- SLOT_WIDTH, 512, width of one packet-buffer slot; matches PACKET_BUFFER_SLOT_WIDTH.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- chnl_0_req_valid  in  1  channel 0 fetch request valid.
- chnl_0_req_head  in  SLOT_NUM_LOG  head slot of the packet to fetch.
- chnl_0_req_ready  out  1  request accepted.
- chnl_0_resp_valid  out  1  response beat valid.
- chnl_0_resp_start  out  1  first beat of the packet.
- chnl_0_resp_last  out  1  final beat of the packet.
- chnl_0_resp_data  out  SLOT_WIDTH  slot payload.
- chnl_0_resp_ready  in  1  channel 0 accepts the beat.
- chnl_1_*: same set as chnl_0_*, for channel 1.
- fetch_req_valid  out  1  request to the buffer.
- fetch_req_head  out  SLOT_NUM_LOG  head slot forwarded to the buffer.
- fetch_req_ready  in  1  buffer accepts the request.
- fetch_resp_valid  in  1  buffer response beat valid.
- fetch_resp_start  in  1  first beat.
- fetch_resp_last  in  1  final beat.
- fetch_resp_data  in  SLOT_WIDTH  slot payload.
- fetch_resp_ready  out  1  arbiter accepts the beat.

Behaviour:
- States: IDLE, REQ_0, REQ_1, RESP_0, RESP_1. State register and last_sch_chnl (1 bit) are reset asynchronously on rst_n low to IDLE and 0.
- IDLE arbitration, with "other" meaning the channel not in last_sch_chnl:
  - If the other channel is valid, go to REQ of the other channel.
  - Else if the last-scheduled channel is valid, go to REQ of that channel.
  - Else stay in IDLE.
  - Consequence: after reset, with both channels valid, channel 1 wins first.
- REQ_x:
  - fetch_req_valid = chnl_x_req_valid; fetch_req_head = chnl_x_req_head; chnl_x_req_ready = fetch_req_ready.
  - Advance to RESP_x on the cycle where fetch_req_valid && fetch_req_ready.
- RESP_x:
  - chnl_x_resp_{valid,start,last,data} = fetch_resp_*; fetch_resp_ready = chnl_x_resp_ready.
  - On fetch_resp_valid && fetch_resp_ready && fetch_resp_last: go to IDLE and set last_sch_chnl = x.
- Ungranted outputs: all valid/ready/start/last/head/data outputs not routed in the current state are driven to 0. fetch_resp_ready = 0 in IDLE and REQ_x, so stray responses stall and are not dropped.
- Latency:
  - Request forwarding and response steering are combinational within a state.
  - Grant costs 1 cycle (IDLE to REQ).
  - Minimum turnaround between packets is 1 IDLE cycle.
- Handshake rules:
  - Requesters hold valid/head stable until ready.
  - The buffer returns exactly one start-to-last response burst per accepted request.
  - A single-beat packet has start and last both set.
- Simultaneous events: request acceptance and first response beat in the same cycle is impossible by construction. The response is only routed from RESP_x, so the buffer must wait at least one cycle.
- Reset mid-operation: the state returns to IDLE immediately. Any in-flight burst is abandoned; the buffer is reset in the same domain.
- Invalid state encoding: the default case returns to IDLE.

Optional Feature:
- Macro: DB_FETCH_ARB_STAT_EN.
- When defined:
  - Adds outputs chnl_0_fetch_cnt and chnl_1_fetch_cnt, 32 bits each.
  - Each counter increments on that channel's last response beat handshake and saturates at 0xFFFFFFFF.
  - Counters reset to 0.
- When undefined: no counters, no extra ports; behaviour otherwise identical.

Decomposition:
- Shared protocol_engine_def header: slot width macros, plus channel index constants CHNL_0/CHNL_1.
- No sub-module. A round-robin picker is trivial and stays inline; the optional stat counters stay in a generate/ifdef block.

Test Plan:
- Reset, then chnl_0 only requests head 0x005 and the buffer returns 3 beats (start on beat 0, last on beat 2) → fetch_req_head = 0x005; chnl_0 receives all 3 beats; chnl_1_resp_valid stays 0; back to IDLE; last_sch_chnl = 0.
- Both channels request in the same cycle after reset (heads 0x010, 0x020) → chnl_1 is served first (0x020), then chnl_0 (0x010); responses are never cross-routed.
- Buffer asserts fetch_resp_valid while the arbiter is in REQ_0 → fetch_resp_ready = 0 until state RESP_0.
- chnl_1_resp_ready held low for 4 cycles mid-burst → fetch_resp_ready low for the same 4 cycles; data held; no beat lost; grant retained.
- rst_n asserted during beat 2 of a 5-beat burst → all outputs 0 in the same cycle; IDLE after release; a new request is granted normally.
- DB_FETCH_ARB_STAT_EN defined, 3 chnl_0 fetches and 2 chnl_1 fetches → chnl_0_fetch_cnt = 3, chnl_1_fetch_cnt = 2.
